// File: rtl/kernel_cmd_sequencer_pkg.sv
// Shared definitions for the kernel command sequencer.
// Holds the sequencer state type, the reserved command codes and the
// bit positions of the status readback word.
package kernel_cmd_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_ISSUE,
    ST_RUN
  } state_t;

  localparam logic [7:0] CMD_NOP   = 8'h00;
  localparam logic [7:0] CMD_ABORT = 8'hFF;

  localparam int unsigned SW_LAST_CMD_LSB = 0;
  localparam int unsigned SW_COUNT_LSB    = 8;
  localparam int unsigned SW_BUSY         = 12;
  localparam int unsigned SW_OVERFLOW     = 13;
  localparam int unsigned SW_TIMEOUT      = 14;
  localparam int unsigned SW_DONE_LSB     = 16;

endpackage

// File: rtl/kernel_cmd_sequencer_fifo.sv
// cmd_fifo: command queue for the kernel command sequencer.
// Ports: clk/rstn (async active-low), flush (empties the queue),
// wr_en/wr_data (ignored when full), rd_en (ignored when empty),
// rd_data (head entry, combinational), full, empty, count (entries held).
module cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty   = (wr_ptr == rd_ptr);
    full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    count   = wr_ptr - rd_ptr;
    rd_data = mem[rd_ptr[AW-1:0]];
  end

  always_comb begin
    do_wr = wr_en && !full && !flush;
    do_rd = rd_en && !empty && !flush;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/kernel_cmd_sequencer.sv
// kernel_cmd_sequencer: queues kernel commands from the register block and
// issues them one at a time to the kernel engine, timing each run.
// Ports: clk/rstn (async active-low); cmd_in/cmd_new (command write, 0x00 = NOP,
// 0xFF = ABORT); clear_errors (clears sticky overflow/timeout);
// engine_idle/engine_done (engine handshake); engine_start/engine_cmd/
// engine_abort (engine control); status_word (readback); last_latency
// (RUN cycles of the last completed command).
module kernel_cmd_sequencer
  import kernel_cmd_sequencer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned CMD_WIDTH      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [CMD_WIDTH-1:0] cmd_in,
  input  logic                 cmd_new,
  input  logic                 clear_errors,
  input  logic                 engine_idle,
  input  logic                 engine_done,
  output logic                 engine_start,
  output logic [CMD_WIDTH-1:0] engine_cmd,
  output logic                 engine_abort,
  output logic [31:0]          status_word,
  output logic [31:0]          last_latency
);

  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  state_t               state;
  logic [CMD_WIDTH-1:0] fifo_rd_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CW-1:0]        fifo_count;

  logic                 is_abort;
  logic                 wr_en;
  logic                 rd_en;
  logic                 ovf_evt;
  logic                 done_evt;
  logic                 to_evt;

  logic [CMD_WIDTH-1:0] last_cmd;
  logic [15:0]          done_count;
  logic                 overflow;
  logic                 timeout_flag;
  logic [31:0]          lat_cnt;

  cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .flush   (is_abort),
    .wr_en   (wr_en),
    .wr_data (cmd_in),
    .rd_en   (rd_en),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  // ABORT overrides everything in its cycle: no dequeue, completion or timeout.
  always_comb begin
    is_abort = cmd_new && (cmd_in == CMD_WIDTH'(CMD_ABORT));
    wr_en    = cmd_new && (cmd_in != CMD_WIDTH'(CMD_NOP)) && !is_abort;
    ovf_evt  = wr_en && fifo_full;
    rd_en    = (state == ST_IDLE) && !fifo_empty && !is_abort;
    done_evt = (state == ST_RUN) && engine_done && !is_abort;
    to_evt   = (state == ST_RUN) && !engine_done && !is_abort && (lat_cnt == TO_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= ST_IDLE;
      engine_start <= 1'b0;
      engine_abort <= 1'b0;
      engine_cmd   <= '0;
      last_cmd     <= '0;
      done_count   <= '0;
      overflow     <= 1'b0;
      timeout_flag <= 1'b0;
      last_latency <= '0;
      lat_cnt      <= '0;
    end else begin
      engine_start <= 1'b0;
      engine_abort <= 1'b0;
      // A new error event in the same cycle as clear_errors wins.
      overflow     <= (overflow && !clear_errors) || ovf_evt;
      timeout_flag <= (timeout_flag && !clear_errors) || to_evt;

      if (is_abort) begin
        engine_abort <= (state == ST_ISSUE) || (state == ST_RUN);
        state        <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (rd_en) begin
              engine_cmd <= fifo_rd_data;
              state      <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (engine_idle) begin
              engine_start <= 1'b1;
              lat_cnt      <= '0;
              state        <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            lat_cnt <= '0;
            state   <= ST_RUN;
          end
          ST_RUN: begin
            if (lat_cnt != '1) lat_cnt <= lat_cnt + 32'd1;
            if (done_evt) begin
              last_latency <= (lat_cnt == '1) ? '1 : lat_cnt + 32'd1;
              last_cmd     <= engine_cmd;
              if (done_count != '1) done_count <= done_count + 16'd1;
              state        <= ST_IDLE;
            end else if (to_evt) begin
              engine_abort <= 1'b1;
              state        <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    status_word                          = '0;
    status_word[SW_LAST_CMD_LSB +: 8]    = 8'(last_cmd);
    status_word[SW_COUNT_LSB +: 4]       = 4'(fifo_count);
    status_word[SW_BUSY]                 = (state != ST_IDLE);
    status_word[SW_OVERFLOW]             = overflow;
    status_word[SW_TIMEOUT]              = timeout_flag;
    status_word[SW_DONE_LSB +: 16]       = done_count;
  end

endmodule

// File: tb/tb_kernel_cmd_sequencer.sv
module tb_kernel_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [7:0]  cmd_in = '0;
  logic        cmd_new = 1'b0;
  logic        clear_errors = 1'b0;
  logic        engine_idle = 1'b0;
  logic        engine_done = 1'b0;
  logic        engine_start;
  logic [7:0]  engine_cmd;
  logic        engine_abort;
  logic [31:0] status_word;
  logic [31:0] last_latency;

  int          errors = 0;
  int          checks = 0;
  int          exp_done = 0;
  logic [31:0] exp_lat = '0;

  kernel_cmd_sequencer #(
    .FIFO_DEPTH     (4),
    .CMD_WIDTH      (8),
    .TIMEOUT_CYCLES (20)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .cmd_in       (cmd_in),
    .cmd_new      (cmd_new),
    .clear_errors (clear_errors),
    .engine_idle  (engine_idle),
    .engine_done  (engine_done),
    .engine_start (engine_start),
    .engine_cmd   (engine_cmd),
    .engine_abort (engine_abort),
    .status_word  (status_word),
    .last_latency (last_latency)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // Drive one command pulse at a falling edge; returns at the next falling edge.
  task automatic push(input logic [7:0] c);
    cmd_in  = c;
    cmd_new = 1'b1;
    @(negedge clk);
    cmd_new = 1'b0;
    cmd_in  = '0;
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (engine_start === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL wait_start: engine_start not seen within 40 cycles");
    end
  endtask

  // Called in the ISSUE cycle; completes the command after len RUN cycles.
  task automatic run_body(input logic [7:0] exp_cmd, input int unsigned len);
    engine_idle = 1'b0;
    for (int unsigned i = 1; i <= len; i++) begin
      @(negedge clk);
      if (i == 1) begin
        checks++;
        if (engine_start !== 1'b0) begin
          errors++;
          $display("FAIL start_pulse_width: got %b expected 0", engine_start);
        end
      end
      if (i == len) begin
        engine_done = 1'b1;
        checks++;
        if (engine_cmd !== exp_cmd) begin
          errors++;
          $display("FAIL cmd_stable_run: got %02h expected %02h", engine_cmd, exp_cmd);
        end
      end
    end
    @(negedge clk);
    engine_done = 1'b0;
    exp_done++;
    exp_lat = 32'(len);
    checks++;
    if (last_latency !== exp_lat) begin
      errors++;
      $display("FAIL last_latency: got %0d expected %0d", last_latency, exp_lat);
    end
    checks++;
    if (status_word[7:0] !== exp_cmd) begin
      errors++;
      $display("FAIL last_cmd: got %02h expected %02h", status_word[7:0], exp_cmd);
    end
    checks++;
    if (status_word[31:16] !== 16'(exp_done)) begin
      errors++;
      $display("FAIL done_count: got %0d expected %0d", status_word[31:16], exp_done);
    end
    checks++;
    if (status_word[12] !== 1'b0) begin
      errors++;
      $display("FAIL busy_after_done: got %b expected 0", status_word[12]);
    end
  endtask

  task automatic run_cmd(input logic [7:0] exp_cmd, input int unsigned len);
    bit found;
    engine_idle = 1'b1;
    wait_start(found);
    if (found) begin
      checks++;
      if (engine_cmd !== exp_cmd) begin
        errors++;
        $display("FAIL issue_order: got %02h expected %02h", engine_cmd, exp_cmd);
      end
      run_body(exp_cmd, len);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({engine_start, engine_abort, engine_cmd} !== 10'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got start=%b abort=%b cmd=%02h expected 0", engine_start, engine_abort, engine_cmd);
    end
    checks++;
    if (status_word !== 32'd0) begin
      errors++;
      $display("FAIL reset_status: got %08h expected 00000000", status_word);
    end
    checks++;
    if (last_latency !== 32'd0) begin
      errors++;
      $display("FAIL reset_latency: got %0d expected 0", last_latency);
    end
  endtask

  task automatic test_basic();
    logic [2:0] seen;
    engine_idle = 1'b1;
    push(8'h05);
    seen[0] = engine_start;
    @(negedge clk);
    seen[1] = engine_start;
    @(negedge clk);
    seen[2] = engine_start;
    checks++;
    if (seen !== 3'b100) begin
      errors++;
      $display("FAIL start_latency: got %b expected 100 (cycles 1..3 after cmd_new)", seen);
    end
    checks++;
    if (engine_cmd !== 8'h05) begin
      errors++;
      $display("FAIL basic_cmd: got %02h expected 05", engine_cmd);
    end
    run_body(8'h05, 10);
  endtask

  task automatic test_overflow();
    engine_idle = 1'b0;
    for (int i = 1; i <= 6; i++) push(8'(i));
    checks++;
    if (status_word[11:8] !== 4'd4 || status_word[13] !== 1'b1) begin
      errors++;
      $display("FAIL overflow_fill: got count=%0d ovf=%b expected count=4 ovf=1", status_word[11:8], status_word[13]);
    end
    clear_errors = 1'b1;
    push(8'h07);
    clear_errors = 1'b0;
    checks++;
    if (status_word[11:8] !== 4'd4 || status_word[13] !== 1'b1) begin
      errors++;
      $display("FAIL clear_vs_overflow: got count=%0d ovf=%b expected count=4 ovf=1", status_word[11:8], status_word[13]);
    end
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    checks++;
    if (status_word[13] !== 1'b0) begin
      errors++;
      $display("FAIL overflow_clear: got %b expected 0", status_word[13]);
    end
    for (int i = 1; i <= 5; i++) run_cmd(8'(i), 32'(i + 2));
    checks++;
    if (status_word[11:8] !== 4'd0) begin
      errors++;
      $display("FAIL overflow_drain: got count=%0d expected 0", status_word[11:8]);
    end
  endtask

  task automatic test_abort();
    bit found;
    int starts = 0;
    int aborts = 0;
    engine_idle = 1'b1;
    push(8'h11);
    wait_start(found);
    push(8'h22);
    push(8'h33);
    checks++;
    if (status_word[11:8] !== 4'd2) begin
      errors++;
      $display("FAIL abort_prequeue: got count=%0d expected 2", status_word[11:8]);
    end
    push(8'hFF);
    checks++;
    if (engine_abort !== 1'b1 || status_word[11:8] !== 4'd0 || status_word[12] !== 1'b0) begin
      errors++;
      $display("FAIL abort_effect: got abort=%b count=%0d busy=%b expected 1 0 0", engine_abort, status_word[11:8], status_word[12]);
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (engine_start === 1'b1) starts++;
      if (engine_abort === 1'b1) aborts++;
    end
    checks++;
    if (starts != 0 || aborts != 0) begin
      errors++;
      $display("FAIL abort_after: got starts=%0d extra_aborts=%0d expected 0 0", starts, aborts);
    end
    checks++;
    if (status_word[31:16] !== 16'(exp_done)) begin
      errors++;
      $display("FAIL abort_done_count: got %0d expected %0d", status_word[31:16], exp_done);
    end
  endtask

  task automatic test_timeout();
    bit found;
    int early = 0;
    engine_idle = 1'b1;
    push(8'h42);
    wait_start(found);
    engine_idle = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (engine_abort === 1'b1) early++;
    end
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL timeout_early: got %0d abort cycles expected 0", early);
    end
    @(negedge clk);
    checks++;
    if (engine_abort !== 1'b1 || status_word[14] !== 1'b1 || status_word[12] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_fire: got abort=%b to=%b busy=%b expected 1 1 0", engine_abort, status_word[14], status_word[12]);
    end
    checks++;
    if (status_word[31:16] !== 16'(exp_done) || last_latency !== exp_lat) begin
      errors++;
      $display("FAIL timeout_not_done: got done=%0d lat=%0d expected %0d %0d", status_word[31:16], last_latency, exp_done, exp_lat);
    end
    @(negedge clk);
    checks++;
    if (engine_abort !== 1'b0) begin
      errors++;
      $display("FAIL timeout_abort_width: got %b expected 0", engine_abort);
    end
    clear_errors = 1'b1;
    @(negedge clk);
    clear_errors = 1'b0;
    checks++;
    if (status_word[14] !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear: got %b expected 0", status_word[14]);
    end
  endtask

  // Reference: while the engine is held busy, one command moves into the
  // engine and the queue holds four more; anything beyond that is dropped.
  task automatic test_random();
    logic [7:0] q[$];
    for (int it = 0; it < 8; it++) begin
      int unsigned k = $urandom_range(1, 7);
      int unsigned pushed = 0;
      q.delete();
      engine_idle = 1'b0;
      clear_errors = 1'b1;
      @(negedge clk);
      clear_errors = 1'b0;
      while (pushed < k) begin
        int unsigned r = $urandom_range(0, 3);
        if (r == 0) begin
          @(negedge clk);
        end else if (r == 1) begin
          push(8'h00);
        end else begin
          logic [7:0] c = 8'($urandom_range(1, 254));
          push(c);
          if (pushed < 5) q.push_back(c);
          pushed++;
        end
      end
      @(negedge clk);
      checks++;
      if (status_word[11:8] !== 4'(q.size() - 1) || status_word[13] !== (k > 5)) begin
        errors++;
        $display("FAIL rand_fill[%0d]: got count=%0d ovf=%b expected count=%0d ovf=%b", it, status_word[11:8], status_word[13], q.size() - 1, k > 5);
      end
      while (q.size() > 0) run_cmd(q.pop_front(), $urandom_range(1, 15));
      checks++;
      if (status_word[11:8] !== 4'd0) begin
        errors++;
        $display("FAIL rand_drain[%0d]: got count=%0d expected 0", it, status_word[11:8]);
      end
    end
  endtask

  task automatic test_wait_idle_reset();
    int bad = 0;
    engine_idle = 1'b0;
    push(8'h5A);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (engine_start !== 1'b0 || status_word[12] !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL wait_idle_hold: got %0d bad cycles expected 0", bad);
    end
    engine_idle = 1'b1;
    @(negedge clk);
    checks++;
    if (engine_start !== 1'b1 || engine_cmd !== 8'h5A) begin
      errors++;
      $display("FAIL wait_idle_release: got start=%b cmd=%02h expected 1 5a", engine_start, engine_cmd);
    end
    engine_idle = 1'b0;
    @(negedge clk);
    rstn = 1'b0;
    #1;
    exp_done = 0;
    exp_lat = '0;
    checks++;
    if ({engine_start, engine_abort, engine_cmd} !== 10'd0 || status_word !== 32'd0 || last_latency !== 32'd0) begin
      errors++;
      $display("FAIL midrun_reset: got start=%b abort=%b cmd=%02h status=%08h lat=%0d expected all 0", engine_start, engine_abort, engine_cmd, status_word, last_latency);
    end
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (engine_abort !== 1'b0 || engine_start !== 1'b0 || status_word !== 32'd0) begin
      errors++;
      $display("FAIL post_reset: got abort=%b start=%b status=%08h expected 0 0 0", engine_abort, engine_start, status_word);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    test_reset();
    test_basic();
    test_overflow();
    test_abort();
    test_timeout();
    test_random();
    test_wait_idle_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/kernel_cmd_sequencer.md
KERNEL_CMD_SEQUENCER -- requirements
Module: kernel_cmd_sequencer

Interface
REQ-001 Parameters (name, default, meaning):
- FIFO_DEPTH, 4, command queue entries; power of two, minimum 2.
- CMD_WIDTH, 8, kernel command width.
- TIMEOUT_CYCLES, 65535, maximum RUN cycles before timeout.
REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, clock.
- rstn, in, 1, reset.
- cmd_in, in, CMD_WIDTH, command from the register block (kregs[0][7:0]).
- cmd_new, in, 1, one-cycle pulse; cmd_in is valid in this cycle.
- clear_errors, in, 1, pulse; clears sticky error bits.
- engine_idle, in, 1, engine ready for a new command.
- engine_done, in, 1, one-cycle completion pulse.
- engine_start, out, 1, one-cycle issue pulse.
- engine_cmd, out, CMD_WIDTH, command being executed; held stable from ISSUE through the end of RUN.
- engine_abort, out, 1, one-cycle abort pulse.
- status_word, out, 32, status readback.
- last_latency, out, 32, RUN cycle count of the last completed command.
REQ-003 Reset rstn is asynchronous and active-low; clock is clk.

Function
REQ-004 Queue
- FIFO of FIFO_DEPTH entries.
- cmd_new with cmd_in not in {0x00, 0xFF} enqueues cmd_in when the queue is not full.
- When the queue is full, the command is dropped and overflow is set (sticky).
REQ-005 cmd_in == 0x00 (NOP) is ignored and never enqueued.
REQ-006 cmd_in == 0xFF (ABORT):
- Flushes the queue.
- Pulses engine_abort in the next cycle if the state is ISSUE or RUN.
- Forces IDLE in the next cycle.
- Never enqueued.
- Takes priority over a dequeue in the same cycle.
REQ-007 States: IDLE, WAIT_IDLE, ISSUE, RUN.
REQ-008 IDLE -> WAIT_IDLE when the queue is non-empty; the head entry is dequeued into engine_cmd on this transition.
REQ-009 WAIT_IDLE -> ISSUE in the first cycle engine_idle == 1.
REQ-010 ISSUE
- Lasts exactly one cycle.
- engine_start == 1.
- Latency counter cleared to 0.
- Next state is RUN.
REQ-011 RUN
- Latency counter increments by 1 per cycle and saturates at 0xFFFFFFFF.
- On engine_done: last_latency <= counter + 1; last_cmd <= engine_cmd; done_count increments (saturating at 0xFFFF); next state is IDLE.
REQ-012 RUN timeout
- If the counter reaches TIMEOUT_CYCLES without engine_done: timeout is set (sticky), engine_abort pulses for one cycle, next state is IDLE.
- The command is not counted as completed.
REQ-013 engine_done outside RUN is ignored.
REQ-014 Simultaneous enqueue and dequeue on a non-empty, non-full queue both succeed; the count is unchanged.
REQ-015 Enqueue into an empty queue while in IDLE:
- The entry is dequeued on the following cycle at the earliest.
- Minimum latency from cmd_new to engine_start is 3 cycles when engine_idle == 1.
REQ-016 status_word layout:
- [7:0] last_cmd.
- [11:8] queue count, zero-extended.
- [12] busy (state != IDLE).
- [13] overflow.
- [14] timeout.
- [15] 0.
- [31:16] done_count.
REQ-017 clear_errors clears overflow and timeout. If clear_errors coincides with a new error event, the error bit is set.
REQ-018 Pointer wrap-around: read and write pointers wrap modulo FIFO_DEPTH. Full and empty are distinguished by an extra pointer bit.

Reset
REQ-019 Reset values:
- State: IDLE.
- Queue: empty.
- engine_start, engine_abort: 0.
- engine_cmd: 0.
- last_cmd, done_count, overflow, timeout: 0.
- last_latency: 0.
- Latency counter: 0.
REQ-020 Reset assertion mid-operation returns the block to reset values immediately. No engine_abort is generated.

Structure
REQ-021 The shared package holds the state enum type, the ABORT (0xFF) and NOP (0x00) command codes, and the status_word bit-position constants.
REQ-022 The queue is a sub-module named cmd_fifo (parameterised depth and width, with count output). All other logic is in one comb/ff pair.

Verification
REQ-023 cmd_new with cmd_in = 0x05, engine_idle = 1 -> engine_start 3 cycles later with engine_cmd = 0x05; engine_done 10 cycles after start -> last_latency = 10, status_word[7:0] = 0x05, done_count = 1.
REQ-024 Six cmd_new pulses (0x01..0x06) in consecutive cycles while the engine is busy -> queue count = 4, overflow = 1; commands execute in order 0x01..0x05.
REQ-025 cmd_in = 0xFF during RUN with 2 commands queued -> engine_abort pulses once, queue count = 0, state = IDLE, no engine_start follows.
REQ-026 TIMEOUT_CYCLES = 20, engine_done never asserted -> engine_abort at RUN cycle 20, timeout = 1; a later clear_errors pulse -> status_word[14] = 0.
REQ-027 engine_idle held 0 for 7 cycles with a queued command -> state remains WAIT_IDLE and engine_start stays 0 until engine_idle rises; rstn pulsed during RUN -> all outputs return to reset values.
